// File: rtl/rx_reset_sequencer.sv
// Arbitrates sw / watchdog / packet-timeout reset requests into a length-controlled rx_rst pulse plus hold-off.
// Optional macro RX_RST_DROP_CNT_EN implements drop_count; otherwise drop_count is tied to 0.
module rx_reset_sequencer #(
  parameter int PULSE_LEN_WIDTH = 8,
  parameter int HOLDOFF_WIDTH   = 16,
  parameter int TIMEOUT_WIDTH   = 24,
  parameter int CNT_WIDTH       = 16
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       enable,
  input  logic                       wd_rst_req,
  input  logic                       sw_rst_req,
  input  logic                       power_trigger,
  input  logic                       pkt_done,
  input  logic [PULSE_LEN_WIDTH-1:0] pulse_len,
  input  logic [HOLDOFF_WIDTH-1:0]   holdoff_len,
  input  logic [TIMEOUT_WIDTH-1:0]   timeout_th,
  input  logic                       cnt_clr,
  output logic                       rx_rst,
  output logic [1:0]                 rst_cause,
  output logic [CNT_WIDTH-1:0]       rst_count,
  output logic [CNT_WIDTH-1:0]       drop_count,
  output logic [1:0]                 seq_state
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ASSERT  = 2'd1,
    ST_HOLDOFF = 2'd2
  } state_t;

  state_t                     state_r;
  state_t                     state_nxt_s;
  logic                       issue_s;
  logic [1:0]                 cause_nxt_s;
  logic [PULSE_LEN_WIDTH-1:0] pulse_cnt_r;
  logic [PULSE_LEN_WIDTH-1:0] pulse_load_s;
  logic [HOLDOFF_WIDTH-1:0]   hold_len_r;
  logic [HOLDOFF_WIDTH-1:0]   hold_cnt_r;
  logic [TIMEOUT_WIDTH-1:0]   to_cnt_r;
  logic                       to_run_s;
  logic                       to_hit_s;
  logic                       rx_rst_r;
  logic [1:0]                 rst_cause_r;
  logic [CNT_WIDTH-1:0]       rst_count_r;

  // A zero pulse length still produces a one-cycle pulse.
  assign pulse_load_s = (pulse_len == PULSE_LEN_WIDTH'(0)) ? PULSE_LEN_WIDTH'(0)
                                                            : pulse_len - PULSE_LEN_WIDTH'(1);

  // pkt_done beats a simultaneous expiry, so no timeout request is raised that cycle.
  assign to_run_s = enable && power_trigger && (state_r == ST_IDLE) &&
                    (timeout_th != TIMEOUT_WIDTH'(0));
  assign to_hit_s = to_run_s && !pkt_done && (to_cnt_r >= timeout_th);

  // Next-state and request arbitration; sw is honoured in every state.
  always_comb begin
    state_nxt_s = state_r;
    issue_s     = 1'b0;
    cause_nxt_s = rst_cause_r;
    if (!enable) begin
      state_nxt_s = ST_IDLE;
    end else if (sw_rst_req) begin
      state_nxt_s = ST_ASSERT;
      issue_s     = 1'b1;
      cause_nxt_s = 2'd1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (wd_rst_req) begin
            state_nxt_s = ST_ASSERT;
            issue_s     = 1'b1;
            cause_nxt_s = 2'd2;
          end else if (to_hit_s) begin
            state_nxt_s = ST_ASSERT;
            issue_s     = 1'b1;
            cause_nxt_s = 2'd3;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_ASSERT: begin
          if (pulse_cnt_r != PULSE_LEN_WIDTH'(0)) begin
            state_nxt_s = ST_ASSERT;
          end else if (hold_len_r != HOLDOFF_WIDTH'(0)) begin
            state_nxt_s = ST_HOLDOFF;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_HOLDOFF: begin
          if (hold_cnt_r != HOLDOFF_WIDTH'(0)) begin
            state_nxt_s = ST_HOLDOFF;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State, pulse/hold-off counters and the registered reset output.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r     <= ST_IDLE;
      pulse_cnt_r <= PULSE_LEN_WIDTH'(0);
      hold_len_r  <= HOLDOFF_WIDTH'(0);
      hold_cnt_r  <= HOLDOFF_WIDTH'(0);
      rx_rst_r    <= 1'b0;
      rst_cause_r <= 2'd0;
    end else begin
      state_r  <= state_nxt_s;
      rx_rst_r <= (state_nxt_s == ST_ASSERT);
      if (issue_s) begin
        pulse_cnt_r <= pulse_load_s;
        hold_len_r  <= holdoff_len;
        rst_cause_r <= cause_nxt_s;
      end else if ((state_r == ST_ASSERT) && (pulse_cnt_r != PULSE_LEN_WIDTH'(0))) begin
        pulse_cnt_r <= pulse_cnt_r - PULSE_LEN_WIDTH'(1);
      end
      if ((state_r == ST_ASSERT) && (state_nxt_s == ST_HOLDOFF)) begin
        hold_cnt_r <= hold_len_r - HOLDOFF_WIDTH'(1);
      end else if ((state_r == ST_HOLDOFF) && (hold_cnt_r != HOLDOFF_WIDTH'(0))) begin
        hold_cnt_r <= hold_cnt_r - HOLDOFF_WIDTH'(1);
      end
    end
  end

  // Packet timeout counter, running only while idle with energy detected.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      to_cnt_r <= TIMEOUT_WIDTH'(0);
    end else if (!to_run_s || pkt_done || to_hit_s || (state_nxt_s != ST_IDLE)) begin
      to_cnt_r <= TIMEOUT_WIDTH'(0);
    end else begin
      to_cnt_r <= to_cnt_r + TIMEOUT_WIDTH'(1);
    end
  end

  // Saturating reset counter; clear beats a same-cycle increment.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rst_count_r <= CNT_WIDTH'(0);
    end else if (cnt_clr) begin
      rst_count_r <= CNT_WIDTH'(0);
    end else if (issue_s && (rst_count_r != {CNT_WIDTH{1'b1}})) begin
      rst_count_r <= rst_count_r + CNT_WIDTH'(1);
    end
  end

`ifdef RX_RST_DROP_CNT_EN
  logic                 wd_d_r;
  logic                 drop_evt_s;
  logic [CNT_WIDTH-1:0] drop_count_r;

  // Ignored requests count once per watchdog rising edge or per timeout expiry.
  assign drop_evt_s = enable && (state_r != ST_IDLE) &&
                      ((wd_rst_req && !wd_d_r) || to_hit_s);

  // Watchdog edge history and saturating drop counter.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_d_r       <= 1'b0;
      drop_count_r <= CNT_WIDTH'(0);
    end else begin
      wd_d_r <= wd_rst_req;
      if (cnt_clr) begin
        drop_count_r <= CNT_WIDTH'(0);
      end else if (drop_evt_s && (drop_count_r != {CNT_WIDTH{1'b1}})) begin
        drop_count_r <= drop_count_r + CNT_WIDTH'(1);
      end
    end
  end

  assign drop_count = drop_count_r;
`else
  assign drop_count = {CNT_WIDTH{1'b0}};
`endif

  assign rx_rst    = rx_rst_r;
  assign rst_cause = rst_cause_r;
  assign rst_count = rst_count_r;
  assign seq_state = state_r;

endmodule

// File: tb/tb_rx_reset_sequencer.sv
// Directed self-checking bench for rx_reset_sequencer; each scenario task checks its own results.
module tb_rx_reset_sequencer;

  logic        clk;
  logic        rstn;
  logic        enable;
  logic        wd_rst_req;
  logic        sw_rst_req;
  logic        power_trigger;
  logic        pkt_done;
  logic [7:0]  pulse_len;
  logic [15:0] holdoff_len;
  logic [23:0] timeout_th;
  logic        cnt_clr;
  logic        rx_rst;
  logic [1:0]  rst_cause;
  logic [15:0] rst_count;
  logic [15:0] drop_count;
  logic [1:0]  seq_state;

  int checks;
  int errors;

  rx_reset_sequencer dut (
    .clk          (clk),
    .rstn         (rstn),
    .enable       (enable),
    .wd_rst_req   (wd_rst_req),
    .sw_rst_req   (sw_rst_req),
    .power_trigger(power_trigger),
    .pkt_done     (pkt_done),
    .pulse_len    (pulse_len),
    .holdoff_len  (holdoff_len),
    .timeout_th   (timeout_th),
    .cnt_clr      (cnt_clr),
    .rx_rst       (rx_rst),
    .rst_cause    (rst_cause),
    .rst_count    (rst_count),
    .drop_count   (drop_count),
    .seq_state    (seq_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One cycle: outputs are stable and inputs may be driven afterwards.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_state(input logic [1:0] want, input string tag);
    for (int i = 0; i < 100; i++) begin
      if (seq_state == want) break;
      tick();
    end
    checks++;
    if (seq_state !== want) begin
      errors++;
      $display("FAIL %s wait: seq_state=%0d expected %0d", tag, seq_state, want);
    end
  endtask

  task automatic clear_counts();
    cnt_clr = 1'b1;
    tick();
    cnt_clr = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({rx_rst, rst_cause, rst_count, drop_count, seq_state} !== 36'd0) begin
      errors++;
      $display("FAIL reset_state: rx_rst=%0d cause=%0d count=%0d drop=%0d state=%0d expected all 0",
               rx_rst, rst_cause, rst_count, drop_count, seq_state);
    end
  endtask

  task automatic test_wd_pulse();
    int hi, hold, first_hi;
    hi = 0; hold = 0; first_hi = -1;
    pulse_len = 8'd4; holdoff_len = 16'd10;
    wd_rst_req = 1'b1;
    for (int i = 0; i < 15; i++) begin
      tick();
      wd_rst_req = 1'b0;
      if (i == 0) begin
        checks++;
        if (rst_cause !== 2'd2 || rst_count !== 16'd1) begin
          errors++;
          $display("FAIL wd_cause_count: cause=%0d count=%0d expected 2 1", rst_cause, rst_count);
        end
      end
      if (rx_rst === 1'b1) begin
        hi++;
        if (first_hi < 0) first_hi = i;
      end
      if (seq_state === 2'd2) hold++;
    end
    checks++;
    if (hi != 4 || first_hi != 0) begin
      errors++;
      $display("FAIL wd_pulse_len: high=%0d first=%0d expected 4 0", hi, first_hi);
    end
    checks++;
    if (hold != 10) begin
      errors++;
      $display("FAIL wd_holdoff_len: got %0d expected 10", hold);
    end
    checks++;
    if (seq_state !== 2'd0) begin
      errors++;
      $display("FAIL wd_back_idle: state=%0d expected 0", seq_state);
    end
  endtask

  task automatic test_sw_priority();
    int hi;
    hi = 0;
    clear_counts();
    checks++;
    if (rst_count !== 16'd0) begin
      errors++;
      $display("FAIL cnt_clr: count=%0d expected 0", rst_count);
    end
    // clear together with an sw request: clear wins, sequence still starts
    cnt_clr = 1'b1; sw_rst_req = 1'b1;
    tick();
    cnt_clr = 1'b0; sw_rst_req = 1'b0;
    checks++;
    if (rst_count !== 16'd0 || rx_rst !== 1'b1 || rst_cause !== 2'd1) begin
      errors++;
      $display("FAIL clr_vs_inc: count=%0d rx_rst=%0d cause=%0d expected 0 1 1", rst_count, rx_rst, rst_cause);
    end
    wait_state(2'd0, "clr_vs_inc");
    sw_rst_req = 1'b1; wd_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0; wd_rst_req = 1'b0;
    checks++;
    if (rst_cause !== 2'd1 || rst_count !== 16'd1) begin
      errors++;
      $display("FAIL sw_over_wd: cause=%0d count=%0d expected 1 1", rst_cause, rst_count);
    end
    wait_state(2'd2, "sw_holdoff");
    tick(); tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    checks++;
    if (rx_rst !== 1'b1 || seq_state !== 2'd1 || rst_count !== 16'd2 || rst_cause !== 2'd1) begin
      errors++;
      $display("FAIL sw_restart: rx_rst=%0d state=%0d count=%0d cause=%0d expected 1 1 2 1",
               rx_rst, seq_state, rst_count, rst_cause);
    end
    for (int i = 0; i < 8; i++) begin
      if (rx_rst === 1'b1) hi++;
      tick();
    end
    checks++;
    if (hi != 4) begin
      errors++;
      $display("FAIL sw_restart_len: high=%0d expected 4", hi);
    end
    wait_state(2'd0, "sw_done");
  endtask

  task automatic test_timeout();
    int n;
    int seen;
    logic [15:0] base;
    timeout_th = 24'd100;
    power_trigger = 1'b1;
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (rx_rst === 1'b1) begin
        n = i;
        break;
      end
    end
    power_trigger = 1'b0;
    checks++;
    if (n != 101 || rst_cause !== 2'd3) begin
      errors++;
      $display("FAIL timeout_latency: cycles=%0d cause=%0d expected 101 3", n, rst_cause);
    end
    wait_state(2'd0, "timeout_done");
    tick();
    // pkt_done at cycle 99 keeps the counter from reaching the threshold
    base = rst_count;
    seen = 0;
    power_trigger = 1'b1;
    for (int i = 0; i < 150; i++) begin
      pkt_done = (i == 99);
      tick();
      if (rx_rst === 1'b1) seen++;
    end
    pkt_done = 1'b0;
    power_trigger = 1'b0;
    tick();
    checks++;
    if (seen != 0 || rst_count !== base) begin
      errors++;
      $display("FAIL timeout_pkt_done: resets=%0d count=%0d expected 0 %0d", seen, rst_count, base);
    end
    // pkt_done in the very cycle the counter equals the threshold
    seen = 0;
    power_trigger = 1'b1;
    for (int i = 0; i < 120; i++) begin
      pkt_done = (i == 100);
      tick();
      if (rx_rst === 1'b1) seen++;
    end
    pkt_done = 1'b0;
    power_trigger = 1'b0;
    timeout_th = 24'd0;
    tick();
    checks++;
    if (seen != 0 || rst_count !== base) begin
      errors++;
      $display("FAIL timeout_tie: resets=%0d count=%0d expected 0 %0d", seen, rst_count, base);
    end
  endtask

  task automatic test_drop();
    logic [15:0] exp_drop;
`ifdef RX_RST_DROP_CNT_EN
    exp_drop = 16'd3;
`else
    exp_drop = 16'd0;
`endif
    pulse_len = 8'd4; holdoff_len = 16'd10;
    clear_counts();
    wd_rst_req = 1'b1;
    tick();
    wd_rst_req = 1'b0;
    wait_state(2'd2, "drop_holdoff");
    for (int i = 0; i < 3; i++) begin
      wd_rst_req = 1'b1;
      tick();
      wd_rst_req = 1'b0;
      tick();
    end
    wait_state(2'd0, "drop_done");
    tick();
    checks++;
    if (drop_count !== exp_drop || rst_count !== 16'd1) begin
      errors++;
      $display("FAIL drop_count: drop=%0d count=%0d expected %0d 1", drop_count, rst_count, exp_drop);
    end
    clear_counts();
    checks++;
    if (drop_count !== 16'd0 || rst_count !== 16'd0) begin
      errors++;
      $display("FAIL drop_clear: drop=%0d count=%0d expected 0 0", drop_count, rst_count);
    end
  endtask

  task automatic test_back_to_back();
    int hi;
    pulse_len = 8'd0; holdoff_len = 16'd0;
    clear_counts();
    wd_rst_req = 1'b1;
    tick();
    wd_rst_req = 1'b0;
    checks++;
    if (rx_rst !== 1'b1 || seq_state !== 2'd1) begin
      errors++;
      $display("FAIL min_pulse_on: rx_rst=%0d state=%0d expected 1 1", rx_rst, seq_state);
    end
    tick();
    checks++;
    if (rx_rst !== 1'b0 || seq_state !== 2'd0) begin
      errors++;
      $display("FAIL min_pulse_off: rx_rst=%0d state=%0d expected 0 0", rx_rst, seq_state);
    end
    hi = 0;
    wd_rst_req = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (rx_rst === 1'b1) hi++;
    end
    wd_rst_req = 1'b0;
    tick(); tick();
    checks++;
    if (hi != 5 || rst_count !== 16'd6) begin
      errors++;
      $display("FAIL wd_level_reissue: high=%0d count=%0d expected 5 6", hi, rst_count);
    end
  endtask

  task automatic test_abort();
    logic [15:0] base;
    pulse_len = 8'd8; holdoff_len = 16'd4;
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    tick();
    rstn = 1'b0;
    #1;
    checks++;
    if ({rx_rst, rst_cause, rst_count, drop_count, seq_state} !== 36'd0) begin
      errors++;
      $display("FAIL async_reset: rx_rst=%0d cause=%0d count=%0d drop=%0d state=%0d expected all 0",
               rx_rst, rst_cause, rst_count, drop_count, seq_state);
    end
    #1;
    rstn = 1'b1;
    tick();
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    tick();
    base = rst_count;
    enable = 1'b0;
    tick();
    checks++;
    if (rx_rst !== 1'b0 || seq_state !== 2'd0 || rst_count !== 16'd1 || rst_cause !== 2'd1) begin
      errors++;
      $display("FAIL enable_abort: rx_rst=%0d state=%0d count=%0d cause=%0d expected 0 0 1 1",
               rx_rst, seq_state, rst_count, rst_cause);
    end
    sw_rst_req = 1'b1;
    tick();
    sw_rst_req = 1'b0;
    checks++;
    if (rx_rst !== 1'b0 || rst_count !== base) begin
      errors++;
      $display("FAIL disabled_ignore: rx_rst=%0d count=%0d expected 0 %0d", rx_rst, rst_count, base);
    end
    enable = 1'b1;
    tick();
  endtask

  initial begin
    checks = 0; errors = 0;
    rstn = 1'b0; enable = 1'b1; wd_rst_req = 1'b0; sw_rst_req = 1'b0;
    power_trigger = 1'b0; pkt_done = 1'b0; cnt_clr = 1'b0;
    pulse_len = 8'd4; holdoff_len = 16'd10; timeout_th = 24'd0;
    tick(); tick();
    test_reset();
    rstn = 1'b1;
    tick();
    test_wd_pulse();
    test_sw_priority();
    test_timeout();
    test_drop();
    test_back_to_back();
    test_abort();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rx_reset_sequencer.md
Name: rx_reset_sequencer

Overview:
Consumes reset requests from the receive-side signal watchdog, from software, and from an internal packet-timeout monitor.
Arbitrates the requests and drives a registered, length-controlled reset pulse into the OFDM receive pipeline, followed by a programmable hold-off window.
Records the cause of the last reset and keeps a saturating reset counter for the register file.
Sits between signal_watchdog and the rx pipeline's reset inputs.

Parameters:
PULSE_LEN_WIDTH, 8, width of pulse_len input
HOLDOFF_WIDTH, 16, width of holdoff_len input
TIMEOUT_WIDTH, 24, width of timeout counter and timeout_th input
CNT_WIDTH, 16, width of rst_count / drop_count

Ports:
clk  in  1  clock
rstn  in  1  asynchronous active-low reset
enable  in  1  block enable; 0 forces IDLE and rx_rst=0, clears timeout counter
wd_rst_req  in  1  reset request from signal_watchdog (level, sampled every cycle)
sw_rst_req  in  1  software reset request (single-cycle pulse)
power_trigger  in  1  receiver energy detect; timeout counter runs only while high
pkt_done  in  1  end-of-packet strobe (FCS checked or aborted); clears timeout counter
pulse_len  in  PULSE_LEN_WIDTH  rx_rst high duration in cycles; 0 treated as 1
holdoff_len  in  HOLDOFF_WIDTH  cycles after pulse during which wd/timeout requests are ignored
timeout_th  in  TIMEOUT_WIDTH  packet timeout in cycles; 0 disables timeout
cnt_clr  in  1  synchronous clear of rst_count and drop_count
rx_rst  out  1  registered reset to rx pipeline, active high
rst_cause  out  2  cause of most recent reset: 0 none, 1 sw, 2 watchdog, 3 timeout
rst_count  out  CNT_WIDTH  saturating count of issued resets
drop_count  out  CNT_WIDTH  wd/timeout requests ignored during ASSERT/HOLDOFF (see Optional Feature)
seq_state  out  2  current FSM state, for debug

Behaviour:
- Reset (rstn=0, async): state=IDLE, rx_rst=0, rst_cause=0, rst_count=0, drop_count=0, all internal counters 0.
- States: IDLE=0, ASSERT=1, HOLDOFF=2.
- Request resolution in IDLE:
  - Priority sw > wd > timeout.
  - A request sampled in cycle N gives rx_rst=1 from cycle N+1, the ASSERT state, rst_cause updated and rst_count+1 (saturating at all-ones).
- ASSERT:
  - rx_rst=1 for exactly max(pulse_len,1) cycles.
  - Then HOLDOFF if holdoff_len!=0, else IDLE.
  - rx_rst=0 on the transition cycle.
- HOLDOFF:
  - rx_rst=0; counts holdoff_len cycles, then IDLE.
  - wd_rst_req and timeout requests are ignored here and in ASSERT.
  - An ignored request is counted once per rising edge of wd_rst_req, or once per timeout expiry.
- sw_rst_req:
  - Honoured in any state.
  - In ASSERT or HOLDOFF it restarts ASSERT with a full pulse, sets rst_cause=1 and increments rst_count.
- Timeout counter:
  - Increments each cycle while enable && power_trigger && state==IDLE && timeout_th!=0.
  - Cleared on pkt_done, power_trigger=0, or leaving IDLE.
  - Reaching timeout_th raises a timeout request that cycle, and the counter clears.
  - If pkt_done and counter==timeout_th occur in the same cycle, pkt_done wins and no reset is issued.
- wd_rst_req is level-sensitive in IDLE. If it is still high on return to IDLE, a new reset is issued; this is intended, because the watchdog keeps requesting while the fault persists.
- enable deasserted mid-ASSERT: rx_rst drops the next cycle, state=IDLE, counters and cause retained.
- cnt_clr simultaneous with an increment: clear wins, result 0.
- pulse_len and holdoff_len are sampled on entry to ASSERT. Changes mid-sequence take effect on the next sequence.

Optional Feature:
RX_RST_DROP_CNT_EN:
- Defined: drop_count is implemented as described, saturating, and cleared by cnt_clr.
- Undefined: the drop counter logic is removed and drop_count is tied to 0.

Test Plan:
- wd_rst_req 1-cycle pulse in IDLE, pulse_len=4, holdoff_len=10 -> rx_rst high cycles N+1..N+4, HOLDOFF 10 cycles, rst_cause=2, rst_count=1.
- sw_rst_req and wd_rst_req same cycle -> rst_cause=1, rst_count=1; sw_rst_req again 3 cycles into HOLDOFF -> new 4-cycle pulse, rst_count=2.
- power_trigger held, timeout_th=100, no pkt_done -> rx_rst rises 101 cycles after power_trigger rise, rst_cause=3. Repeat with pkt_done at cycle 99 -> no reset.
- Three wd_rst_req pulses during HOLDOFF with RX_RST_DROP_CNT_EN defined -> drop_count=3, rst_count unchanged. Undefined -> drop_count=0.
- pulse_len=0, holdoff_len=0 -> 1-cycle rx_rst, then immediate IDLE. wd_rst_req held high -> reset re-issued every 2 cycles.
- rstn asserted mid-ASSERT -> rx_rst=0 immediately and asynchronously, all outputs 0. enable=0 mid-ASSERT -> rx_rst=0 next cycle, rst_count retained.
